mlp_layer_seq: RTL and testbench
================================

// Module: mlp_layer_seq
// PURPOSE
//  Sequencer for the 64-lane MLP processing unit (pu). Per image, runs layers 1..5:
//  clears the MACs, streams x/weight addresses, then drains the 64 results.
//  Hidden-layer results (layers 1-4) go to temp_buffer; output-layer results (layer 5) go to y_buffer.
//  Loops over N_IMG images; start/done handshake to the top-level host FSM.
// PARAMETERS
//  N_IMG    20   images per run (img_cnt 0..N_IMG-1, must be <=32)
//  IN1      784  input length of layer 1 (image pixels)
//  INH      64   input length of layers 2..5 (temp_buffer words)
//  RD_LAT   1    read latency of image/temp/weight buffers, cycles
//  MAC_LAT  2    MAC pipeline + pu mac_buf register, cycles
//  XAW      10   x address width;  WAW 12 weight row address width
// PORTS
//  clk        in   1    clock
//  rstn       in   1    asynchronous active-low reset
//  start      in   1    pulse: begin run (ignored unless idle)
//  busy       out  1    high from accepted start until done
//  done       out  1    one-cycle pulse after last y write of last image
//  mac_enable out  1    to pu.enable, aligned with buffer read data
//  mac_clear  out  1    to pu.clear
//  pu_signal  out  1    to pu.signal (drain window)
//  pu_state   out  3    to pu.state = current layer 1..5, 0 when idle
//  img_cnt    out  5    to pu.img_cnt, current image
//  x_sel      out  1    0 = image buffer, 1 = temp_buffer as x source
//  x_addr     out  XAW  x read address
//  w_addr     out  WAW  weight row address (row = 64 packed 20-bit weights)
//  tbuf_we    out  1    temp_buffer write enable (pu.out1 valid)
//  ybuf_we    out  1    y_buffer write enable (pu.out2 valid)
//  wr_addr    out  11   tbuf: {5'b0,idx}; ybuf: {img_cnt,idx}
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0.
//  FSM: IDLE -start-> CLEAR(1 cyc, mac_clear=1) -> FEED(N cyc) -> FLUSH(RD_LAT+MAC_LAT+1 cyc)
//   -> DRAIN(64 cyc, pu_signal=1) -> GAP(1 cyc, pu_signal=0) -> next layer CLEAR, or
//   after layer 5: next image CLEAR (img_cnt+1), or after image N_IMG-1: DONE(1 cyc) -> IDLE.
//  FEED: k=0..N-1, N=IN1 for layer 1 else INH; x_addr=k; x_sel=(layer!=1).
//   w_addr = layer base + k; base(1)=0, base(L)=IN1+(L-2)*INH.
//  mac_enable = FEED-valid delayed RD_LAT cycles (exactly N enable cycles per layer).
//  GAP is mandatory: pu drain counter resets only while signal is low.
//  Writes: pu output is registered, so write valid = pu_signal delayed 1 cycle;
//   idx = drain count delayed 1 (0..63). Layers 1-4 -> tbuf_we; layer 5 -> ybuf_we.
//   The write of idx 63 falls in GAP; the next CLEAR must not precede it.
//  temp_buffer overwrite is safe: all reads of a layer finish before its drain starts.
//  pu_state holds the layer through CLEAR..GAP; it changes only at GAP exit.
//  start while busy: ignored. Reset mid-run: immediate IDLE, no done, no write.
//  Counters: k is 10-bit and saturates at N-1, never wraps; idx wraps 63->0 only at DRAIN end.
// STRUCTURE
//  Package mlp_pkg: FSM state enum, layer numbers (L_IN=1..L_OUT=5), NEURONS=64.
//  Sub-module: mlp_delay_line (parametrised shift register) used for the enable
//   delay and the write-valid/idx delay; everything else lives in one FSM plus counters.
// TESTING
//  Use IN1=8, INH=4, N_IMG=2, RD_LAT=1, MAC_LAT=2 for short sims.
//  Reset: all outputs 0; no activity without start.
//  Single run: start -> mac_enable high 8 cyc (layer 1), 4 cyc (layers 2-5);
//   w_addr bases 0,8,12,16,20; done once; busy low after done.
//  Drain: per layer 64 pu_signal cycles, then 64 write pulses one cycle later,
//   idx 0..63; layer 5 of image 1: ybuf addr 64..127.
//  Ignore start while busy: extra pulses mid-run -> no restart, exactly one done.
//  Async reset asserted in FEED of layer 3 -> outputs 0 at once; a new start runs fully.
//  Scoreboard: golden pu output, 2 images -> y_buffer contents match reference MLP model.

Source files
------------

// File: rtl/mlp_pkg.sv
// ---------------------------------------------------------------------------
// mlp_pkg
// Shared definitions for the MLP layer sequencer: the sequencer FSM state
// type, the layer numbering used on pu_state, and the neuron count of the
// 64-lane processing unit.
// ---------------------------------------------------------------------------
package mlp_pkg;

    // Sequencer states, one per phase of a layer pass plus run bookkeeping
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } seq_state_t;

    // Layer numbers as seen by the pu; 0 on pu_state means idle
    localparam logic [2:0] L_IN  = 3'd1;
    localparam logic [2:0] L_OUT = 3'd5;

    // One result per lane is drained per layer
    localparam int NEURONS = 64;
    localparam int IDX_W   = $clog2(NEURONS);

    // Hidden layers write temp_buffer, the output layer writes y_buffer
    function automatic logic isHidden(input logic [2:0] layer);
        return (layer >= L_IN) && (layer < L_OUT);
    endfunction

endpackage

// File: rtl/mlp_delay_line.sv
// ---------------------------------------------------------------------------
// mlp_delay_line
// Parametrised shift register that delays a WIDTH-bit bus by DEPTH clock
// cycles. DEPTH of 0 degenerates to a plain wire.
//
// Ports
//   clk   in   1      clock
//   rstn  in   1      asynchronous active-low reset, clears every stage
//   i_d   in   WIDTH  data in
//   o_q   out  WIDTH  data in, DEPTH cycles later
// ---------------------------------------------------------------------------
module mlp_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Stage 0 captures the input, every later stage copies its predecessor
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mlp_layer_seq.sv
// ---------------------------------------------------------------------------
// mlp_layer_seq
// Sequencer for the 64-lane MLP processing unit. For every image it runs
// layers 1..5: clear the MACs, stream x/weight read addresses, wait for the
// MAC pipeline to settle, then drain the 64 results. Hidden-layer results go
// to temp_buffer, output-layer results to y_buffer. Loops over N_IMG images
// and reports completion with a one-cycle done pulse.
//
// Ports
//   clk           in   1     clock
//   rstn          in   1     asynchronous active-low reset
//   i_start       in   1     begin a run (ignored unless idle)
//   o_busy        out  1     high from accepted start until done
//   o_done        out  1     one-cycle pulse after the last y write
//   o_mac_enable  out  1     pu.enable, aligned with buffer read data
//   o_mac_clear   out  1     pu.clear
//   o_pu_signal   out  1     pu.signal, drain window
//   o_pu_state    out  3     current layer 1..5, 0 when idle
//   o_img_cnt     out  5     current image
//   o_x_sel       out  1     0 = image buffer, 1 = temp_buffer
//   o_x_addr      out  XAW   x read address
//   o_w_addr      out  WAW   weight row address
//   o_tbuf_we     out  1     temp_buffer write enable
//   o_ybuf_we     out  1     y_buffer write enable
//   o_wr_addr     out  11    tbuf: {5'b0,idx}, ybuf: {img_cnt,idx}
// ---------------------------------------------------------------------------
module mlp_layer_seq
    import mlp_pkg::*;
#(
    parameter int N_IMG   = 20,
    parameter int IN1     = 784,
    parameter int INH     = 64,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2,
    parameter int XAW     = 10,
    parameter int WAW     = 12
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_mac_enable,
    output logic           o_mac_clear,
    output logic           o_pu_signal,
    output logic [2:0]     o_pu_state,
    output logic [4:0]     o_img_cnt,
    output logic           o_x_sel,
    output logic [XAW-1:0] o_x_addr,
    output logic [WAW-1:0] o_w_addr,
    output logic           o_tbuf_we,
    output logic           o_ybuf_we,
    output logic [10:0]    o_wr_addr
);

    // The last read needs RD_LAT cycles to reach the MACs and MAC_LAT more to
    // land in the pu output register; one extra cycle keeps the first drained
    // word clear of the final accumulate.
    localparam int FLUSH_LEN = RD_LAT + MAC_LAT + 1;
    localparam int FCW       = $clog2(FLUSH_LEN + 1);

    localparam logic [XAW-1:0]   K_LAST_IN1 = XAW'(IN1 - 1);
    localparam logic [XAW-1:0]   K_LAST_INH = XAW'(INH - 1);
    localparam logic [FCW-1:0]   FLUSH_LAST = FCW'(FLUSH_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NEURONS - 1);
    localparam logic [4:0]       IMG_LAST   = 5'(N_IMG - 1);

    seq_state_t       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_macClear;
    logic             r_feedValid;
    logic             r_puSignal;
    logic [2:0]       r_layer;
    logic [4:0]       r_imgCnt;
    logic             r_xSel;
    logic [XAW-1:0]   r_kCnt;
    logic [WAW-1:0]   r_wAddr;
    logic [FCW-1:0]   r_flushCnt;
    logic [IDX_W-1:0] r_drainCnt;

    logic [XAW-1:0]   w_kLast;
    logic             w_macEnable;
    logic [IDX_W:0]   w_wrBus;
    logic             w_wrValid;
    logic [IDX_W-1:0] w_wrIdx;
    logic             w_isOut;
    logic [10:0]      w_wrAddr;

    // First weight row of a layer: layer 1 owns rows 0..IN1-1, every later
    // layer owns INH rows packed right after it.
    function automatic logic [WAW-1:0] layerBase(input logic [2:0] layer);
        if (layer == L_IN) begin
            return '0;
        end
        return WAW'(IN1 + (int'(layer) - 2) * INH);
    endfunction

    assign w_kLast = (r_layer == L_IN) ? K_LAST_IN1 : K_LAST_INH;

    // Layer/image sequencing. Every output leaves this block as a register
    // that already reflects the state being entered, so the pu sees clean
    // controls aligned with the state register. pu_state (r_layer) is held
    // from CLEAR through GAP and only moves on GAP exit, so the write of
    // idx 63, which lands in GAP, is still steered by the layer that made it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_macClear  <= 1'b0;
            r_feedValid <= 1'b0;
            r_puSignal  <= 1'b0;
            r_layer     <= '0;
            r_imgCnt    <= '0;
            r_xSel      <= 1'b0;
            r_kCnt      <= '0;
            r_wAddr     <= '0;
            r_flushCnt  <= '0;
            r_drainCnt  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_CLEAR;
                        r_busy     <= 1'b1;
                        r_macClear <= 1'b1;
                        r_layer    <= L_IN;
                        r_imgCnt   <= '0;
                        r_xSel     <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_state     <= S_FEED;
                    r_macClear  <= 1'b0;
                    r_feedValid <= 1'b1;
                    r_kCnt      <= '0;
                    r_wAddr     <= layerBase(r_layer);
                end
                S_FEED: begin
                    // k stops at N-1 rather than wrapping; it doubles as x_addr
                    if (r_kCnt == w_kLast) begin
                        r_state     <= S_FLUSH;
                        r_feedValid <= 1'b0;
                        r_flushCnt  <= '0;
                    end else begin
                        r_kCnt  <= r_kCnt + XAW'(1);
                        r_wAddr <= r_wAddr + WAW'(1);
                    end
                end
                S_FLUSH: begin
                    if (r_flushCnt == FLUSH_LAST) begin
                        r_state    <= S_DRAIN;
                        r_puSignal <= 1'b1;
                        r_drainCnt <= '0;
                    end else begin
                        r_flushCnt <= r_flushCnt + FCW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drainCnt == IDX_LAST) begin
                        r_state    <= S_GAP;
                        r_puSignal <= 1'b0;
                        r_drainCnt <= '0;
                    end else begin
                        r_drainCnt <= r_drainCnt + IDX_W'(1);
                    end
                end
                S_GAP: begin
                    // One cycle with signal low lets the pu reset its own
                    // drain counter and lets the idx-63 write retire.
                    if (r_layer != L_OUT) begin
                        r_state    <= S_CLEAR;
                        r_macClear <= 1'b1;
                        r_layer    <= r_layer + 3'd1;
                        r_xSel     <= 1'b1;
                    end else if (r_imgCnt != IMG_LAST) begin
                        r_state    <= S_CLEAR;
                        r_macClear <= 1'b1;
                        r_layer    <= L_IN;
                        r_imgCnt   <= r_imgCnt + 5'd1;
                        r_xSel     <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_layer <= '0;
                        r_xSel  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_imgCnt <= '0;
                    r_kCnt   <= '0;
                    r_wAddr  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Buffer read data arrives RD_LAT cycles after the address, so the MAC
    // enable is the feed window pushed back by the same amount.
    mlp_delay_line #(
        .WIDTH (1),
        .DEPTH (RD_LAT)
    ) u_enDelay (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (r_feedValid),
        .o_q  (w_macEnable)
    );

    // The pu registers its drained word, so the write strobe and index trail
    // the drain window by one cycle.
    mlp_delay_line #(
        .WIDTH (IDX_W + 1),
        .DEPTH (1)
    ) u_wrDelay (
        .clk  (clk),
        .rstn (rstn),
        .i_d  ({r_puSignal, r_drainCnt}),
        .o_q  (w_wrBus)
    );

    assign w_wrValid = w_wrBus[IDX_W];
    assign w_wrIdx   = w_wrBus[IDX_W-1:0];
    assign w_isOut   = (r_layer == L_OUT);
    assign w_wrAddr  = !w_wrValid ? 11'd0 :
                       (w_isOut ? {r_imgCnt, w_wrIdx} : {5'd0, w_wrIdx});

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_mac_enable = w_macEnable;
    assign o_mac_clear  = r_macClear;
    assign o_pu_signal  = r_puSignal;
    assign o_pu_state   = r_layer;
    assign o_img_cnt    = r_imgCnt;
    assign o_x_sel      = r_xSel;
    assign o_x_addr     = r_kCnt;
    assign o_w_addr     = r_wAddr;
    assign o_tbuf_we    = w_wrValid & isHidden(r_layer);
    assign o_ybuf_we    = w_wrValid & w_isOut;
    assign o_wr_addr    = w_wrAddr;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_mlp_layer_seq
// Drives mlp_layer_seq with short-sim parameters, surrounds it with a
// behavioural pu plus image/temp/weight/y buffers, and compares the y_buffer
// contents with a plain arithmetic MLP reference computed from the same
// random data. Also checks enable counts, weight bases, drain/write timing,
// start-while-busy and asynchronous reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_mlp_layer_seq;

    localparam int N_IMG = 2;
    localparam int IN1   = 8;
    localparam int INH   = 4;
    localparam int NROWS = IN1 + 4 * INH;
    localparam int NN    = 64;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        busy;
    logic        done;
    logic        macEnable;
    logic        macClear;
    logic        puSignal;
    logic [2:0]  puState;
    logic [4:0]  imgCnt;
    logic        xSel;
    logic [9:0]  xAddr;
    logic [11:0] wAddr;
    logic        tbufWe;
    logic        ybufWe;
    logic [10:0] wrAddr;

    int total;
    int bad;

    // Environment memories and behavioural pu state
    int imgMem [N_IMG][IN1];
    int wMem   [NROWS][NN];
    int tbuf   [NN];
    int ybuf   [N_IMG*NN];
    int acc    [NN];
    int rdW    [NN];
    int rdX;
    int puOut;
    int drCnt;
    int refY   [N_IMG][NN];

    // Per-run observations
    int enCount  [N_IMG][6];
    int sigCount [N_IMG][6];
    int wrCount  [N_IMG][6];
    int firstW   [N_IMG][6];
    int doneCnt;
    int errWr;
    int errSel;
    int errClr;
    int expIdx;
    int stSeq [$];
    int prevSig;
    int prevEn;
    int prevW;
    int prevState;

    mlp_layer_seq #(
        .N_IMG   (N_IMG),
        .IN1     (IN1),
        .INH     (INH),
        .RD_LAT  (1),
        .MAC_LAT (2),
        .XAW     (10),
        .WAW     (12)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_mac_enable (macEnable),
        .o_mac_clear  (macClear),
        .o_pu_signal  (puSignal),
        .o_pu_state   (puState),
        .o_img_cnt    (imgCnt),
        .o_x_sel      (xSel),
        .o_x_addr     (xAddr),
        .o_w_addr     (wAddr),
        .o_tbuf_we    (tbufWe),
        .o_ybuf_we    (ybufWe),
        .o_wr_addr    (wrAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neuron activation shared by the pu model and the reference MLP
    function automatic int act(input int v);
        if (v < 0) return 0;
        return (v >>> 2) & 255;
    endfunction

    // Behavioural pu, buffers and protocol observers. Everything here looks
    // at the values present just before the clock edge.
    always @(posedge clk) begin
        int lay;
        int im;
        int expAddr;
        if (!rstn) begin
            prevSig   = 0;
            prevEn    = 0;
            prevW     = 0;
            prevState = 0;
            drCnt     = 0;
        end else begin
            if (start && !busy) begin
                for (int i = 0; i < N_IMG; i++) begin
                    for (int l = 0; l < 6; l++) begin
                        enCount[i][l]  = 0;
                        sigCount[i][l] = 0;
                        wrCount[i][l]  = 0;
                        firstW[i][l]   = -1;
                    end
                end
                for (int a = 0; a < N_IMG*NN; a++) ybuf[a] = -1;
                doneCnt = 0;
                errWr   = 0;
                errSel  = 0;
                errClr  = 0;
                expIdx  = 0;
                stSeq.delete();
            end
            lay = int'(puState);
            im  = int'(imgCnt);
            if (lay != prevState) stSeq.push_back(lay);
            if (lay >= 1 && lay <= 5 && im < N_IMG) begin
                if (macEnable) begin
                    enCount[im][lay]++;
                    if (prevEn == 0) firstW[im][lay] = prevW;
                end
                if (puSignal) sigCount[im][lay]++;
                if (tbufWe || ybufWe) wrCount[im][lay]++;
            end
            // Writes land one cycle after the drained word, in index order
            if (tbufWe || ybufWe) begin
                if (prevSig == 0) errWr++;
                if (tbufWe && ybufWe) errWr++;
                if (ybufWe != (lay == 5)) errWr++;
                expAddr = ybufWe ? (im * NN + expIdx) : expIdx;
                if (int'(wrAddr) != expAddr) errWr++;
                if (ybufWe) begin
                    if (int'(wrAddr) < N_IMG*NN) ybuf[wrAddr] = puOut;
                end else begin
                    tbuf[wrAddr[5:0]] = puOut;
                end
                expIdx = (expIdx + 1) % NN;
            end
            if (busy && (xSel != (lay >= 2))) errSel++;
            if (macClear && (prevSig != 0 || tbufWe || ybufWe)) errClr++;
            if (done) doneCnt++;
            if (macClear) begin
                for (int j = 0; j < NN; j++) acc[j] = 0;
            end else if (macEnable) begin
                for (int j = 0; j < NN; j++) acc[j] += rdX * rdW[j];
            end
            if (puSignal) begin
                puOut = act(acc[drCnt % NN]);
                drCnt++;
            end else begin
                drCnt = 0;
            end
            if (xSel) rdX = tbuf[xAddr[5:0]];
            else if (im < N_IMG && int'(xAddr) < IN1) rdX = imgMem[im][xAddr];
            else rdX = 0;
            for (int j = 0; j < NN; j++) begin
                rdW[j] = (int'(wAddr) < NROWS) ? wMem[wAddr][j] : 0;
            end
            prevSig   = int'(puSignal);
            prevEn    = int'(macEnable);
            prevW     = int'(wAddr);
            prevState = lay;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string p);
        checkOutput({p, "_busy"},   32'(busy), 0);
        checkOutput({p, "_done"},   32'(done), 0);
        checkOutput({p, "_en"},     32'(macEnable), 0);
        checkOutput({p, "_clr"},    32'(macClear), 0);
        checkOutput({p, "_sig"},    32'(puSignal), 0);
        checkOutput({p, "_state"},  32'(puState), 0);
        checkOutput({p, "_img"},    32'(imgCnt), 0);
        checkOutput({p, "_xsel"},   32'(xSel), 0);
        checkOutput({p, "_xaddr"},  32'(xAddr), 0);
        checkOutput({p, "_waddr"},  32'(wAddr), 0);
        checkOutput({p, "_tbufwe"}, 32'(tbufWe), 0);
        checkOutput({p, "_ybufwe"}, 32'(ybufWe), 0);
        checkOutput({p, "_wraddr"}, 32'(wrAddr), 0);
    endtask

    task automatic applyStimulus();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic loadMemories();
        for (int i = 0; i < N_IMG; i++)
            for (int k = 0; k < IN1; k++) imgMem[i][k] = int'($urandom_range(0, 15));
        for (int r = 0; r < NROWS; r++)
            for (int j = 0; j < NN; j++) wMem[r][j] = int'($urandom_range(0, 15)) - 8;
    endtask

    // Straight MLP: five dense layers, weight rows packed layer after layer
    task automatic computeRef();
        int h  [NN];
        int hn [NN];
        int s;
        int base;
        for (int i = 0; i < N_IMG; i++) begin
            for (int j = 0; j < NN; j++) begin
                s = 0;
                for (int k = 0; k < IN1; k++) s += imgMem[i][k] * wMem[k][j];
                h[j] = act(s);
            end
            for (int l = 2; l <= 5; l++) begin
                base = IN1 + (l - 2) * INH;
                for (int j = 0; j < NN; j++) begin
                    s = 0;
                    for (int k = 0; k < INH; k++) s += h[k] * wMem[base + k][j];
                    hn[j] = act(s);
                end
                for (int j = 0; j < NN; j++) h[j] = hn[j];
            end
            for (int j = 0; j < NN; j++) refY[i][j] = h[j];
        end
    endtask

    task automatic runAndCheck(input bit extraStarts, input string t);
        int cyc;
        int e1;
        int e2;
        int mis;
        int expBase;
        int expSeq;
        e1  = int'($urandom_range(20, 300));
        e2  = int'($urandom_range(301, 700));
        cyc = 0;
        applyStimulus();
        while (doneCnt == 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (extraStarts && (cyc == e1 || cyc == e2));
        end
        start = 1'b0;
        checkOutput({t, "_done_seen"}, 32'(doneCnt > 0), 1);
        repeat (30) @(negedge clk);
        checkOutput({t, "_done_count"}, 32'(doneCnt), 1);
        checkOutput({t, "_busy_after"}, 32'(busy), 0);
        checkOutput({t, "_state_after"}, 32'(puState), 0);
        for (int i = 0; i < N_IMG; i++) begin
            for (int l = 1; l <= 5; l++) begin
                expBase = (l == 1) ? 0 : IN1 + (l - 2) * INH;
                checkOutput($sformatf("%s_en_i%0d_l%0d", t, i, l), 32'(enCount[i][l]), (l == 1) ? IN1 : INH);
                checkOutput($sformatf("%s_wbase_i%0d_l%0d", t, i, l), 32'(firstW[i][l]), 32'(expBase));
                checkOutput($sformatf("%s_sig_i%0d_l%0d", t, i, l), 32'(sigCount[i][l]), NN);
                checkOutput($sformatf("%s_wr_i%0d_l%0d", t, i, l), 32'(wrCount[i][l]), NN);
            end
        end
        checkOutput({t, "_wr_protocol"}, 32'(errWr), 0);
        checkOutput({t, "_xsel"}, 32'(errSel), 0);
        checkOutput({t, "_clear_vs_write"}, 32'(errClr), 0);
        checkOutput({t, "_state_seq_len"}, 32'(stSeq.size()), N_IMG * 5 + 1);
        for (int n = 0; n < N_IMG * 5 + 1; n++) begin
            expSeq = (n == N_IMG * 5) ? 0 : (n % 5) + 1;
            checkOutput($sformatf("%s_state_seq%0d", t, n), (n < stSeq.size()) ? 32'(stSeq[n]) : 32'hFFFF_FFFF, 32'(expSeq));
        end
        for (int i = 0; i < N_IMG; i++) begin
            mis = 0;
            for (int j = 0; j < NN; j++) if (ybuf[i*NN + j] != refY[i][j]) mis++;
            checkOutput($sformatf("%s_y_img%0d_mismatches", t, i), 32'(mis), 0);
        end
    endtask

    initial begin
        int quiet;
        int found;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        start = 1'b0;
        doneCnt = 0;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");

        @(negedge clk) rstn = 1'b1;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy || done || macEnable || macClear || puSignal || tbufWe || ybufWe || puState != 3'd0) quiet++;
        end
        checkOutput("idle_no_activity", 32'(quiet), 0);

        $display("[TB] run 1: full run with extra start pulses while busy");
        loadMemories();
        computeRef();
        runAndCheck(1'b1, "run1");

        $display("[TB] async reset during layer 3 feed");
        loadMemories();
        computeRef();
        applyStimulus();
        found = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            @(negedge clk);
            if (puState == 3'd3 && xAddr == 10'd2 && imgCnt == 5'd0) found = 1;
        end
        checkOutput("reach_l3_feed", 32'(found), 1);
        #2 rstn = 1'b0;
        #1;
        checkAllZero("async_rst");
        repeat (3) @(negedge clk);
        checkOutput("rst_hold_busy", 32'(busy), 0);
        checkOutput("rst_no_done", 32'(doneCnt), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 0);
        checkOutput("post_rst_state", 32'(puState), 0);

        $display("[TB] run 2: fresh start after reset");
        runAndCheck(1'b0, "run2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
